// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register ids and datapath widths.
package y86_pkg;

  localparam int unsigned RegW  = 4;
  localparam int unsigned WordW = 64;
  localparam int unsigned NumRegs = 15;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [RegW-1:0] RNONE = 4'hF;
  localparam logic [RegW-1:0] RRSP  = 4'h4;

endpackage

// File: rtl/y86_regfile.sv
// 15x64 architectural register file: two async read ports, a debug port, and E/M write ports
// where M wins when both target the same register.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [WordW-1:0] RSP_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RegW-1:0]  rd_a_sel,
  output logic [WordW-1:0] rd_a_data,
  input  logic [RegW-1:0]  rd_b_sel,
  output logic [WordW-1:0] rd_b_data,
  input  logic [RegW-1:0]  dbg_sel,
  output logic [WordW-1:0] dbg_data,
  input  logic [RegW-1:0]  wr_e_sel,
  input  logic [WordW-1:0] wr_e_data,
  input  logic [RegW-1:0]  wr_m_sel,
  input  logic [WordW-1:0] wr_m_data
);

  logic [WordW-1:0] rf_q [NumRegs];
  logic [WordW-1:0] rf_d [NumRegs];

  always_comb begin
    rf_d = rf_q;
    if (wr_e_sel != RNONE) rf_d[wr_e_sel] = wr_e_data;
    // M port applied last so it takes the collision (popq %rsp)
    if (wr_m_sel != RNONE) rf_d[wr_m_sel] = wr_m_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rd_a_data = (rd_a_sel == RNONE) ? '0 : rf_q[rd_a_sel];
    rd_b_data = (rd_b_sel == RNONE) ? '0 : rf_q[rd_b_sel];
    dbg_data  = (dbg_sel  == RNONE) ? '0 : rf_q[dbg_sel];
  end

endmodule

// File: rtl/decode_wb_stage.sv
// Y86-64 decode/write-back stage: register-id decode, operand forwarding and the register file
// written from the W pipeline register.
module decode_wb_stage
  import y86_pkg::*;
#(
  parameter logic [WordW-1:0] RSP_INIT = 64'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [RegW-1:0]  D_rA,
  input  logic [RegW-1:0]  D_rB,
  input  logic [WordW-1:0] D_valP,
  input  logic [RegW-1:0]  e_dstE,
  input  logic [WordW-1:0] e_valE,
  input  logic [RegW-1:0]  M_dstE,
  input  logic [WordW-1:0] M_valE,
  input  logic [RegW-1:0]  M_dstM,
  input  logic [WordW-1:0] m_valM,
  input  logic [RegW-1:0]  W_dstE,
  input  logic [WordW-1:0] W_valE,
  input  logic [RegW-1:0]  W_dstM,
  input  logic [WordW-1:0] W_valM,
  input  logic [RegW-1:0]  dbg_sel,
  output logic [RegW-1:0]  d_srcA,
  output logic [RegW-1:0]  d_srcB,
  output logic [RegW-1:0]  d_dstE,
  output logic [RegW-1:0]  d_dstM,
  output logic [WordW-1:0] d_valA,
  output logic [WordW-1:0] d_valB,
  output logic [WordW-1:0] dbg_data
);

  logic [WordW-1:0] rf_a, rf_b;

  y86_regfile #(
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_a_sel  (d_srcA),
    .rd_a_data (rf_a),
    .rd_b_sel  (d_srcB),
    .rd_b_data (rf_b),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .wr_e_sel  (W_dstE),
    .wr_e_data (W_valE),
    .wr_m_sel  (W_dstM),
    .wr_m_data (W_valM)
  );

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
      I_RET, I_POPQ:                      d_srcA = RRSP;
      default:                            ;
    endcase
    case (D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:         d_srcB = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_srcB = RRSP;
      default:                           ;
    endcase
    case (D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:         d_dstE = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_dstE = RRSP;
      default:                           ;
    endcase
    case (D_icode)
      I_MRMOVQ, I_POPQ: d_dstM = D_rA;
      default:          ;
    endcase
  end

  // Youngest producer first; RNONE sources short-circuit so an RNONE dst can never match.
  function automatic logic [WordW-1:0] fwd(input logic [RegW-1:0] src,
                                            input logic [WordW-1:0] rf_val);
    if (src == RNONE)       return '0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_val;
  endfunction

  always_comb begin
    if (D_icode == I_JXX || D_icode == I_CALL) begin
      d_valA = D_valP;
    end else begin
      d_valA = fwd(d_srcA, rf_a);
    end
    d_valB = fwd(d_srcB, rf_b);
  end

endmodule

// File: tb/tb_decode_wb_stage.sv
// Directed bench for decode_wb_stage: expectations queued per step, then drained against the DUT.
module tb_decode_wb_stage;

  localparam logic [63:0] RspInit = 64'h200;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_icode, D_rA, D_rB;
  logic [63:0] D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, dbg_sel;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB, dbg_data;

  typedef enum int {SigSrcA, SigSrcB, SigDstE, SigDstM, SigValA, SigValB, SigDbg} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  decode_wb_stage #(
    .RSP_INIT (RspInit)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .D_icode  (D_icode),
    .D_rA     (D_rA),
    .D_rB     (D_rB),
    .D_valP   (D_valP),
    .e_dstE   (e_dstE),
    .e_valE   (e_valE),
    .M_dstE   (M_dstE),
    .M_valE   (M_valE),
    .M_dstM   (M_dstM),
    .m_valM   (m_valM),
    .W_dstE   (W_dstE),
    .W_valE   (W_valE),
    .W_dstM   (W_dstM),
    .W_valM   (W_valM),
    .dbg_sel  (dbg_sel),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .d_dstE   (d_dstE),
    .d_dstM   (d_dstM),
    .d_valA   (d_valA),
    .d_valB   (d_valB),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] observe(input sig_e s);
    case (s)
      SigSrcA: return {60'd0, d_srcA};
      SigSrcB: return {60'd0, d_srcB};
      SigDstE: return {60'd0, d_dstE};
      SigDstM: return {60'd0, d_dstM};
      SigValA: return d_valA;
      SigValB: return d_valB;
      default: return dbg_data;
    endcase
  endfunction

  task automatic push_exp(input string tag, input sig_e s, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.sig);
      n_checks++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_icode = 4'h1; D_rA = 4'hF; D_rB = 4'hF; D_valP = '0;
    e_dstE = 4'hF; e_valE = '0; M_dstE = 4'hF; M_valE = '0;
    M_dstM = 4'hF; m_valM = '0; W_dstE = 4'hF; W_valE = '0;
    W_dstM = 4'hF; W_valM = '0;
  endtask

  initial begin
    idle_inputs();
    dbg_sel = 4'h4;
    reset   = 1'b1;
    tick();
    reset = 1'b0;

    push_exp("rst_dbg_rsp", SigDbg, 64'h200);
    push_exp("rst_srcA", SigSrcA, 64'hF);
    push_exp("rst_srcB", SigSrcB, 64'hF);
    push_exp("rst_dstE", SigDstE, 64'hF);
    push_exp("rst_dstM", SigDstM, 64'hF);
    push_exp("rst_valA", SigValA, 64'h0);
    push_exp("rst_valB", SigValB, 64'h0);
    drain();
    dbg_sel = 4'h3;
    push_exp("rst_dbg_r3", SigDbg, 64'h0);
    drain();
    dbg_sel = 4'hF;
    push_exp("rst_dbg_rnone", SigDbg, 64'h0);
    drain();

    // Write r2 while an OPQ reads it: W path forwards in the same cycle.
    W_dstE = 4'h2; W_valE = 64'h55;
    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h2;
    push_exp("wfwd_valA", SigValA, 64'h55);
    drain();
    tick();
    W_dstE = 4'hF; W_valE = '0;
    push_exp("rf_valA", SigValA, 64'h55);
    push_exp("rf_valB", SigValB, 64'h55);
    push_exp("op_dstE", SigDstE, 64'h2);
    push_exp("op_srcA", SigSrcA, 64'h2);
    push_exp("op_dstM", SigDstM, 64'hF);
    drain();

    // Forwarding priority on srcA=3; srcB=2 stays on the register file.
    D_rA = 4'h3;
    e_dstE = 4'h3; e_valE = 64'h1;
    M_dstE = 4'h3; M_valE = 64'h2;
    W_dstE = 4'h3; W_valE = 64'h3;
    push_exp("prio_e", SigValA, 64'h1);
    push_exp("prio_valB_rf", SigValB, 64'h55);
    drain();
    M_dstM = 4'h3; m_valM = 64'h9;
    push_exp("prio_e_over_mM", SigValA, 64'h1);
    drain();
    e_dstE = 4'hF;
    push_exp("prio_mM_over_ME", SigValA, 64'h9);
    drain();
    M_dstM = 4'hF;
    push_exp("prio_ME", SigValA, 64'h2);
    drain();
    M_dstE = 4'hF;
    push_exp("prio_WE", SigValA, 64'h3);
    drain();
    W_dstM = 4'h3; W_valM = 64'h4;
    push_exp("prio_WM_over_WE", SigValA, 64'h4);
    drain();
    idle_inputs();

    // rsp = 0x100, then CALL.
    W_dstE = 4'h4; W_valE = 64'h100;
    tick();
    idle_inputs();
    D_icode = 4'h8; D_valP = 64'h1234;
    push_exp("call_valA", SigValA, 64'h1234);
    push_exp("call_valB", SigValB, 64'h100);
    push_exp("call_srcA", SigSrcA, 64'hF);
    push_exp("call_srcB", SigSrcB, 64'h4);
    push_exp("call_dstE", SigDstE, 64'h4);
    push_exp("call_dstM", SigDstM, 64'hF);
    drain();
    D_icode = 4'h7; D_valP = 64'hABC;
    push_exp("jxx_valA", SigValA, 64'hABC);
    push_exp("jxx_srcB", SigSrcB, 64'hF);
    drain();

    // E/M collision on rsp: M wins.
    W_dstE = 4'h4; W_valE = 64'hA0;
    W_dstM = 4'h4; W_valM = 64'hBEEF;
    tick();
    idle_inputs();
    dbg_sel = 4'h4;
    D_icode = 4'h8;
    push_exp("coll_dbg", SigDbg, 64'hBEEF);
    push_exp("coll_valB", SigValB, 64'hBEEF);
    drain();

    // Establish r1 then show reset beats a simultaneous write.
    W_dstE = 4'h1; W_valE = 64'h11;
    tick();
    dbg_sel = 4'h1;
    W_dstE = 4'hF;
    push_exp("r1_written", SigDbg, 64'h11);
    drain();
    reset = 1'b1;
    W_dstE = 4'h1; W_valE = 64'h77;
    tick();
    reset = 1'b0;
    idle_inputs();
    push_exp("rst_over_wr", SigDbg, 64'h0);
    drain();
    dbg_sel = 4'h4;
    push_exp("rst2_rsp", SigDbg, 64'h200);
    drain();

    D_icode = 4'hB; D_rA = 4'h5;
    push_exp("pop_srcA", SigSrcA, 64'h4);
    push_exp("pop_srcB", SigSrcB, 64'h4);
    push_exp("pop_dstM", SigDstM, 64'h5);
    push_exp("pop_dstE", SigDstE, 64'h4);
    push_exp("pop_valA", SigValA, 64'h200);
    drain();

    D_icode = 4'hC; D_rA = 4'h2; D_rB = 4'h2;
    push_exp("undef_srcA", SigSrcA, 64'hF);
    push_exp("undef_srcB", SigSrcB, 64'hF);
    push_exp("undef_dstE", SigDstE, 64'hF);
    push_exp("undef_dstM", SigDstM, 64'hF);
    push_exp("undef_valA", SigValA, 64'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
